// File: rtl/mtimer_pkg.sv
// Register map, reset values and helpers for the TL-UL machine timer.
package mtimer_pkg;

  localparam logic [4:0] MTIMER_CTRL_OFFSET        = 5'h00;
  localparam logic [4:0] MTIMER_PRESCALE_OFFSET    = 5'h04;
  localparam logic [4:0] MTIMER_MTIME_LO_OFFSET    = 5'h08;
  localparam logic [4:0] MTIMER_MTIME_HI_OFFSET    = 5'h0C;
  localparam logic [4:0] MTIMER_MTIMECMP_LO_OFFSET = 5'h10;
  localparam logic [4:0] MTIMER_MTIMECMP_HI_OFFSET = 5'h14;
  localparam logic [4:0] MTIMER_INTR_STATE_OFFSET  = 5'h18;
  localparam logic [4:0] MTIMER_INTR_ENABLE_OFFSET = 5'h1C;

  localparam logic [63:0] MTIMER_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic        ctrl_en;
    logic [31:0] prescale;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        intr_state;
    logic        intr_enable;
  } mtimer_reg_t;

  localparam mtimer_reg_t MTIMER_REG_RST = '{
    ctrl_en:     1'b0,
    prescale:    32'h0,
    mtime:       64'h0,
    mtimecmp:    MTIMER_MTIMECMP_RST,
    intr_state:  1'b0,
    intr_enable: 1'b0
  };

  function automatic logic [31:0] mask_merge(logic [31:0] old, logic [31:0] wdata,
                                             logic [3:0] be);
    logic [31:0] bitmask;
    for (int i = 0; i < 4; i++) bitmask[8*i +: 8] = {8{be[i]}};
    return (old & ~bitmask) | (wdata & bitmask);
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL request/response types shared by crossbar devices.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;

  localparam logic [2:0] AccessAck     = 3'h0;
  localparam logic [2:0] AccessAckData = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/mtimer_tick_gen.sv
// Prescaled tick pulse for mtime. With MTIMER_PRESCALER_EN undefined the tick is
// simply the enable, and clear/prescale are ignored.
module mtimer_tick_gen
  import mtimer_pkg::*;
#(
  parameter int unsigned PrescaleW = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic [PrescaleW-1:0] prescale_i,
  output logic                 tick_o
);

`ifdef MTIMER_PRESCALER_EN
  logic [PrescaleW-1:0] cnt_q, cnt_d;

  // Counter freezes (not clears) while disabled; a PRESCALE write restarts it.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = enable_i & (cnt_q == prescale_i);
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + PrescaleW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tick;
  assign unused_tick = ^{clk_i, rst_ni, clear_i, prescale_i};
  assign tick_o      = enable_i;
`endif

endmodule

// File: rtl/tlul_mtimer.sv
// TL-UL machine timer: 64-bit mtime/mtimecmp with level interrupt. The optional
// tick prescaler is built only when MTIMER_PRESCALER_EN is defined.
module tlul_mtimer
  import tlul_pkg::*;
  import mtimer_pkg::*;
#(
  parameter int unsigned AW        = 8,
  parameter int unsigned PrescaleW = 12
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o,
  output logic    intr_timer_o
);

  localparam logic [31:0] PrescaleMask = 32'((64'd1 << PrescaleW) - 64'd1);

  mtimer_reg_t reg_q, reg_d;
  logic [31:0] shadow_q, shadow_d;

  logic        rsp_pending_q, rsp_pending_d;
  logic [2:0]  rsp_opcode_q, rsp_opcode_d;
  logic [7:0]  rsp_source_q, rsp_source_d;
  logic [1:0]  rsp_size_q, rsp_size_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_error_q, rsp_error_d;

  logic [AW-1:0] off;
  logic [4:0]    reg_off;
  logic          a_acc, is_get, is_put, req_err, wr_en, rd_en;
  logic [31:0]   rdata;
  logic          tick, prescale_clr, cmp_hit;

  logic unused_tl;
  assign unused_tl = ^{tl_i.a_param, tl_i.a_address};

  assign a_acc   = tl_i.a_valid & ~rsp_pending_q;
  assign is_get  = (tl_i.a_opcode == Get);
  assign is_put  = (tl_i.a_opcode == PutFullData) | (tl_i.a_opcode == PutPartialData);
  assign off     = tl_i.a_address[AW-1:0];
  assign reg_off = off[4:0];
  // Every aligned offset below 0x20 is a register, so range + alignment covers decode.
  assign req_err = (off[1:0] != 2'b00) | ((off >> 5) != '0) | ~(is_get | is_put);
  assign wr_en   = a_acc & ~req_err & is_put;
  assign rd_en   = a_acc & ~req_err & is_get;
  assign cmp_hit = (reg_q.mtime >= reg_q.mtimecmp);

  mtimer_tick_gen #(
    .PrescaleW(PrescaleW)
  ) u_tick_gen (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .enable_i  (reg_q.ctrl_en),
    .clear_i   (prescale_clr),
    .prescale_i(reg_q.prescale[PrescaleW-1:0]),
    .tick_o    (tick)
  );

  // Bus writes override the tick increment; a compare hit overrides W1C.
  always_comb begin
    reg_d        = reg_q;
    shadow_d     = shadow_q;
    prescale_clr = 1'b0;
    if (tick) reg_d.mtime = reg_q.mtime + 64'd1;
    if (cmp_hit) reg_d.intr_state = 1'b1;
    if (wr_en) begin
      case (reg_off)
        MTIMER_CTRL_OFFSET: begin
          if (tl_i.a_mask[0]) reg_d.ctrl_en = tl_i.a_data[0];
        end
        MTIMER_PRESCALE_OFFSET: begin
`ifdef MTIMER_PRESCALER_EN
          reg_d.prescale = mask_merge(reg_q.prescale, tl_i.a_data, tl_i.a_mask) & PrescaleMask;
          prescale_clr   = 1'b1;
`endif
        end
        MTIMER_MTIME_LO_OFFSET: begin
          reg_d.mtime = {reg_q.mtime[63:32],
                         mask_merge(reg_q.mtime[31:0], tl_i.a_data, tl_i.a_mask)};
        end
        MTIMER_MTIME_HI_OFFSET: begin
          reg_d.mtime = {mask_merge(reg_q.mtime[63:32], tl_i.a_data, tl_i.a_mask),
                         reg_q.mtime[31:0]};
        end
        MTIMER_MTIMECMP_LO_OFFSET: begin
          reg_d.mtimecmp[31:0] = mask_merge(reg_q.mtimecmp[31:0], tl_i.a_data, tl_i.a_mask);
        end
        MTIMER_MTIMECMP_HI_OFFSET: begin
          reg_d.mtimecmp[63:32] = mask_merge(reg_q.mtimecmp[63:32], tl_i.a_data, tl_i.a_mask);
        end
        MTIMER_INTR_STATE_OFFSET: begin
          if (tl_i.a_mask[0] & tl_i.a_data[0] & ~cmp_hit) reg_d.intr_state = 1'b0;
        end
        MTIMER_INTR_ENABLE_OFFSET: begin
          if (tl_i.a_mask[0]) reg_d.intr_enable = tl_i.a_data[0];
        end
        default: ;
      endcase
    end
    if (rd_en && (reg_off == MTIMER_MTIME_LO_OFFSET)) shadow_d = reg_q.mtime[63:32];
  end

  always_comb begin
    rdata = '0;
    case (reg_off)
      MTIMER_CTRL_OFFSET:        rdata = {31'b0, reg_q.ctrl_en};
      MTIMER_PRESCALE_OFFSET:    rdata = reg_q.prescale;
      MTIMER_MTIME_LO_OFFSET:    rdata = reg_q.mtime[31:0];
      MTIMER_MTIME_HI_OFFSET:    rdata = shadow_q;
      MTIMER_MTIMECMP_LO_OFFSET: rdata = reg_q.mtimecmp[31:0];
      MTIMER_MTIMECMP_HI_OFFSET: rdata = reg_q.mtimecmp[63:32];
      MTIMER_INTR_STATE_OFFSET:  rdata = {31'b0, reg_q.intr_state};
      MTIMER_INTR_ENABLE_OFFSET: rdata = {31'b0, reg_q.intr_enable};
      default:                   rdata = '0;
    endcase
  end

  always_comb begin
    rsp_pending_d = rsp_pending_q;
    rsp_opcode_d  = rsp_opcode_q;
    rsp_source_d  = rsp_source_q;
    rsp_size_d    = rsp_size_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    if (rsp_pending_q && tl_i.d_ready) rsp_pending_d = 1'b0;
    if (a_acc) begin
      rsp_pending_d = 1'b1;
      rsp_opcode_d  = is_get ? AccessAckData : AccessAck;
      rsp_source_d  = tl_i.a_source;
      rsp_size_d    = tl_i.a_size;
      rsp_data_d    = rd_en ? rdata : 32'h0;
      rsp_error_d   = req_err;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q         <= MTIMER_REG_RST;
      shadow_q      <= '0;
      rsp_pending_q <= 1'b0;
      rsp_opcode_q  <= AccessAck;
      rsp_source_q  <= '0;
      rsp_size_q    <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
    end else begin
      reg_q         <= reg_d;
      shadow_q      <= shadow_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_opcode_q  <= rsp_opcode_d;
      rsp_source_q  <= rsp_source_d;
      rsp_size_q    <= rsp_size_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = rsp_pending_q;
    tl_o.d_opcode = rsp_opcode_q;
    tl_o.d_size   = rsp_size_q;
    tl_o.d_source = rsp_source_q;
    tl_o.d_data   = rsp_data_q;
    tl_o.d_error  = rsp_error_q;
    tl_o.a_ready  = ~rsp_pending_q;
  end

  assign intr_timer_o = reg_q.intr_state & reg_q.intr_enable;

endmodule

// File: tb/tb_tlul_mtimer.sv
// Directed bench for tlul_mtimer: a cycle-level register model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_tlul_mtimer;
  import tlul_pkg::*;

`ifdef MTIMER_PRESCALER_EN
  localparam bit PreEn = 1'b1;
`else
  localparam bit PreEn = 1'b0;
`endif

  logic    clk_i = 1'b0;
  logic    rst_ni = 1'b0;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic    intr_timer_o;

  int errors = 0;
  int checks = 0;
  int src_ctr = 0;

  always #5 clk_i = ~clk_i;

  tlul_mtimer #(
    .AW       (8),
    .PrescaleW(12)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .intr_timer_o(intr_timer_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint unsigned m_mtime, m_cmp;
  bit              m_en, m_st, m_ie, m_pend;
  int unsigned     m_pre, m_cnt;
  logic [31:0]     m_shadow, m_rdata;
  logic [2:0]      m_rop;
  bit              m_rerr;
  logic [7:0]      m_rsrc;
  logic [1:0]      m_rsize;

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk_i or negedge rst_ni) begin : model
    bit              hit, tick, acc, err;
    longint unsigned nxt;
    int unsigned     off;
    logic [31:0]     d;
    logic [3:0]      be;
    logic [2:0]      op;
    if (!rst_ni) begin
      m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
      m_en = 0; m_st = 0; m_ie = 0; m_pend = 0;
      m_pre = 0; m_cnt = 0; m_shadow = 0;
      m_rdata = 0; m_rop = 0; m_rerr = 0; m_rsrc = 0; m_rsize = 0;
    end else begin
      hit  = m_mtime >= m_cmp;
      tick = m_en && (!PreEn || m_cnt == m_pre);
      nxt  = tick ? m_mtime + 1 : m_mtime;
      if (PreEn && m_en) m_cnt = tick ? 0 : m_cnt + 1;
      if (hit) m_st = 1;
      acc = tl_i.a_valid && !m_pend;
      if (m_pend && tl_i.d_ready) m_pend = 0;
      if (acc) begin
        off = int'(tl_i.a_address[7:0]);
        d   = tl_i.a_data;
        be  = tl_i.a_mask;
        op  = tl_i.a_opcode;
        err = (off % 4 != 0) || (off > 'h1C) ||
              !(op == PutFullData || op == PutPartialData || op == Get);
        m_rdata = 0; m_rerr = err; m_rsrc = tl_i.a_source; m_rsize = tl_i.a_size;
        m_rop = (op == Get) ? AccessAckData : AccessAck;
        if (!err && op == Get) begin
          case (off)
            'h00: m_rdata = {31'b0, m_en};
            'h04: m_rdata = m_pre;
            'h08: begin m_rdata = m_mtime[31:0]; m_shadow = m_mtime[63:32]; end
            'h0C: m_rdata = m_shadow;
            'h10: m_rdata = m_cmp[31:0];
            'h14: m_rdata = m_cmp[63:32];
            'h18: m_rdata = {31'b0, m_st};
            default: m_rdata = {31'b0, m_ie};
          endcase
        end else if (!err) begin
          case (off)
            'h00: if (be[0]) m_en = d[0];
            'h04: if (PreEn) begin m_pre = merge(m_pre, d, be) & 'hFFF; m_cnt = 0; end
            'h08: nxt = {m_mtime[63:32], merge(m_mtime[31:0], d, be)};
            'h0C: nxt = {merge(m_mtime[63:32], d, be), m_mtime[31:0]};
            'h10: m_cmp = {m_cmp[63:32], merge(m_cmp[31:0], d, be)};
            'h14: m_cmp = {merge(m_cmp[63:32], d, be), m_cmp[31:0]};
            'h18: if (be[0] && d[0] && !hit) m_st = 0;
            default: if (be[0]) m_ie = d[0];
          endcase
        end
        m_pend = 1;
      end
      m_mtime = nxt;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      chk("a_ready", tl_o.a_ready, !m_pend);
      chk("d_valid", tl_o.d_valid, m_pend);
      chk("intr", intr_timer_o, m_st & m_ie);
      if (m_pend) begin
        chk("d_opcode", tl_o.d_opcode, m_rop);
        chk("d_data", tl_o.d_data, m_rdata);
        chk("d_error", tl_o.d_error, m_rerr);
        chk("d_source", tl_o.d_source, m_rsrc);
        chk("d_size", tl_o.d_size, m_rsize);
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic tl_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input int hold,
                        output logic [31:0] rdata, output logic rerr);
    int n;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_data    = data;
    tl_i.a_mask    = mask;
    tl_i.a_size    = 2'd2;
    tl_i.a_source  = 8'(src_ctr);
    src_ctr++;
    if (hold > 0) tl_i.d_ready = 1'b0;
    n = 0;
    while (!tl_o.a_ready && n < 20) begin
      @(posedge clk_i); #1; n++;
    end
    if (n == 20) chk("accept_timeout", 64'(n), 0);
    @(posedge clk_i); #1;
    tl_i.a_valid = 1'b0;
    @(negedge clk_i);
    n = 0;
    while (!tl_o.d_valid && n < 20) begin
      @(negedge clk_i); n++;
    end
    if (n == 20) chk("rsp_timeout", 64'(n), 0);
    rdata = tl_o.d_data;
    rerr  = tl_o.d_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk("hold_a_ready", tl_o.a_ready, 0);
      chk("hold_d_valid", tl_o.d_valid, 1);
    end
    tl_i.d_ready = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r;
    logic        e;
    tl_req(PutFullData, addr, data, 4'hF, 0, r, e);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e;
    tl_req(Get, addr, 32'h0, 4'hF, 0, data, e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] v, lo, hi;
    logic        e;
    int          n;
    tl_i = '0;
    tl_i.d_ready = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_intr", intr_timer_o, 0);
    chk("rst_a_ready", tl_o.a_ready, 1);
    chk("rst_d_valid", tl_o.d_valid, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    rd(32'h10, v); chk("rst_mtimecmp_lo", v, 32'hFFFF_FFFF);
    rd(32'h14, v); chk("rst_mtimecmp_hi", v, 32'hFFFF_FFFF);
    rd(32'h08, v); chk("rst_mtime_lo", v, 0);
    rd(32'h00, v); chk("rst_ctrl", v, 0);
    rd(32'h18, v); chk("rst_intr_state", v, 0);

    // Prescaled counting: PRESCALE=3 gives 10 ticks in ~40 cycles, else 40.
    wr(32'h04, 3);
    wr(32'h00, 1);
    repeat (40) @(posedge clk_i);
    #1;
    rd(32'h08, v);
    if (PreEn) chk("prescale_count", (v >= 9 && v <= 11), 1);
    else       chk("noprescale_count", (v >= 39 && v <= 41), 1);
    wr(32'h00, 0);

    // Atomic LO/HI across the 32-bit carry.
    wr(32'h04, 0);
    wr(32'h08, 32'hFFFF_FFFE);
    wr(32'h0C, 0);
    wr(32'h00, 1);
    rd(32'h08, lo); rd(32'h0C, hi);
    chk("atomic_lo1", lo, 32'hFFFF_FFFF);
    chk("atomic_hi1", hi, 0);
    rd(32'h08, lo); rd(32'h0C, hi);
    chk("atomic_lo2", lo, 3);
    chk("atomic_hi2", hi, 1);
    wr(32'h00, 0);

    // Interrupt set, sticky W1C while hit, clear once below compare.
    wr(32'h08, 0);
    wr(32'h0C, 0);
    wr(32'h14, 0);
    wr(32'h10, 20);
    wr(32'h18, 1);
    wr(32'h1C, 1);
    chk("intr_before", intr_timer_o, 0);
    wr(32'h00, 1);
    n = 0;
    while (intr_timer_o !== 1'b1 && n < 60) begin
      @(negedge clk_i); n++;
    end
    chk("intr_rise", intr_timer_o, 1);
    rd(32'h08, v);
    chk("intr_mtime_ge_20", (v >= 20), 1);
    wr(32'h18, 1);
    chk("intr_w1c_while_hit", intr_timer_o, 1);
    wr(32'h10, 32'hFFFF_FFFF);
    wr(32'h14, 32'hFFFF_FFFF);
    chk("intr_still_set", intr_timer_o, 1);
    wr(32'h18, 1);
    chk("intr_cleared", intr_timer_o, 0);
    rd(32'h18, v); chk("intr_state_read", v, 0);

    // Error responses leave state untouched.
    tl_req(Get, 32'h20, 0, 4'hF, 0, v, e);
    chk("err_oor_flag", e, 1); chk("err_oor_data", v, 0);
    tl_req(Get, 32'h02, 0, 4'hF, 0, v, e);
    chk("err_misalign_flag", e, 1); chk("err_misalign_data", v, 0);
    tl_req(PutFullData, 32'h01, 0, 4'hF, 0, v, e);
    chk("err_misalign_wr", e, 1);
    tl_req(3'h2, 32'h00, 0, 4'hF, 0, v, e);
    chk("err_opcode", e, 1);
    tl_req(PutFullData, 32'h24, 0, 4'hF, 0, v, e);
    chk("err_oor_wr", e, 1);
    rd(32'h00, v); chk("err_ctrl_unchanged", v, 1);
    tl_req(Get, 32'h20, 0, 4'hF, 5, v, e);
    chk("hold_err", e, 1);

    // MTIME_LO write coincident with a tick drops that increment.
    wr(32'h0C, 0);
    wr(32'h08, 100);
    wr(32'h00, 0);
    rd(32'h08, v); chk("write_beats_tick", v, 102);

    // Byte-masked write, PRESCALE width and CTRL RAZ bits.
    tl_req(PutPartialData, 32'h10, 32'h1234_5678, 4'b0101, 0, v, e);
    chk("partial_err", e, 0);
    rd(32'h10, v); chk("partial_cmp_lo", v, 32'hFF34_FF78);
    wr(32'h04, 32'hFFFF_FFFF);
    rd(32'h04, v); chk("prescale_read", v, PreEn ? 32'hFFF : 32'h0);
    wr(32'h00, 32'hFFFF_FFFE);
    rd(32'h00, v); chk("ctrl_raz", v, 0);

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
